// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Sequenced control unit for a multi-cycle core. Accepts one
//            instruction per handshake, latches opcode/funct, and walks it
//            through DECODE/EXEC/MEM/WB/DONE, driving per-state datapath
//            controls. MEM waits on a memory acknowledge.
// Ports    : clk, rst_n (async active-low)
//            instr_valid, opcode, funct   - instruction handshake from fetch
//            mem_ack                      - data memory access complete
//            instr_ready, ir_load         - handshake back to fetch
//            rg_read, rg_write, rg_dst    - register file controls
//            branch, m_read, m_write      - branch / data memory controls
//            pc_write, instr_done         - retire strobes
//            state                        - current state code
//            mem_err                      - sticky memory timeout flag
// Option   : CU_MEM_TIMEOUT_EN enables the MEM wait timeout and mem_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter int OPCODE_W   = 6,
  parameter int FUNCT_W    = 6,
  parameter int TMO_W      = 8,
  parameter int TMO_CYCLES = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ack,
  output logic                instr_ready,
  output logic                ir_load,
  output logic                rg_read,
  output logic                rg_write,
  output logic                rg_dst,
  output logic                branch,
  output logic                m_read,
  output logic                m_write,
  output logic                pc_write,
  output logic                instr_done,
  output logic [2:0]          state,
  output logic                mem_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              cur_state;
  logic [OPCODE_W-1:0] ir_op;
  logic [FUNCT_W-1:0]  ir_fn;

  // Instruction class decode from the latched opcode/funct only.
  logic is_rtype, is_jr, is_br, is_store, is_load, is_noread;
  assign is_rtype  = (ir_op == OPCODE_W'(0));
  assign is_jr     = is_rtype && (ir_fn == FUNCT_W'(8));
  assign is_br     = (ir_op == OPCODE_W'(4)) || (ir_op == OPCODE_W'(5));
  assign is_store  = (ir_op == OPCODE_W'(40)) || (ir_op == OPCODE_W'(41)) ||
                     (ir_op == OPCODE_W'(43));
  assign is_load   = (ir_op == OPCODE_W'(35));
  assign is_noread = (ir_op == OPCODE_W'(21));

`ifdef CU_MEM_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             mem_err_q;
  logic             tmo_hit;
  // The edge on which the count would reach the limit abandons the access.
  assign tmo_hit = (cur_state == S_MEM) && !mem_ack &&
                   (tmo_cnt == TMO_W'(TMO_CYCLES - 1));
  assign mem_err = mem_err_q;
`else
  logic [TMO_W-1:0] tmo_unused;
  assign tmo_unused = TMO_W'(TMO_CYCLES);
  assign mem_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      ir_op     <= '0;
      ir_fn     <= '0;
`ifdef CU_MEM_TIMEOUT_EN
      tmo_cnt   <= '0;
      mem_err_q <= 1'b0;
`endif
    end else begin
      case (cur_state)
        S_IDLE: begin
          if (instr_valid) begin
            ir_op     <= opcode;
            ir_fn     <= funct;
            cur_state <= S_DECODE;
          end
        end
        S_DECODE: cur_state <= S_EXEC;
        S_EXEC: begin
`ifdef CU_MEM_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (is_br || is_jr)          cur_state <= S_DONE;
          else if (is_load || is_store) cur_state <= S_MEM;
          else                          cur_state <= S_WB;
        end
        S_MEM: begin
          // An acknowledge on the limit cycle still completes normally.
          if (mem_ack) begin
            cur_state <= is_load ? S_WB : S_DONE;
          end
`ifdef CU_MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            mem_err_q <= 1'b1;
            cur_state <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        S_WB:    cur_state <= S_DONE;
        S_DONE:  cur_state <= S_IDLE;
        default: cur_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode from the state register and latched instruction; only
  // ir_load looks at the live handshake.
  always_comb begin
    instr_ready = (cur_state == S_IDLE);
    ir_load     = (cur_state == S_IDLE) && instr_valid;
    rg_read     = ((cur_state == S_DECODE) && !is_noread) ||
                  ((cur_state == S_MEM) && is_store);
    rg_write    = (cur_state == S_WB);
    rg_dst      = (cur_state == S_WB) && is_rtype;
    branch      = (cur_state == S_EXEC) && is_br;
    m_read      = (cur_state == S_MEM) && is_load;
    m_write     = (cur_state == S_MEM) && is_store;
    pc_write    = (cur_state == S_DONE);
    instr_done  = (cur_state == S_DONE);
    state       = cur_state;
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// Module   : tb_multicycle_control_unit
// Purpose  : Self-checking bench for multicycle_control_unit: directed
//            sequences pinned with literal expectations, then randomized
//            traffic compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

  localparam int TMO = 4;
  localparam int C_RT = 0, C_JR = 1, C_BR = 2, C_ST = 3, C_LD = 4, C_IM = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       instr_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       mem_ack = 1'b0;
  logic       instr_ready, ir_load, rg_read, rg_write, rg_dst, branch;
  logic       m_read, m_write, pc_write, instr_done, mem_err;
  logic [2:0] state;

  multicycle_control_unit #(
    .OPCODE_W(6), .FUNCT_W(6), .TMO_W(8), .TMO_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct(funct), .mem_ack(mem_ack), .instr_ready(instr_ready),
    .ir_load(ir_load), .rg_read(rg_read), .rg_write(rg_write),
    .rg_dst(rg_dst), .branch(branch), .m_read(m_read), .m_write(m_write),
    .pc_write(pc_write), .instr_done(instr_done), .state(state),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: observable step number, latched instruction, MEM bookkeeping.
  int m_s, m_op, m_fn, m_cnt, m_nmem, cyc, acc;
  bit m_err, m_to;

  int log_st[$], log_done[$], log_mrd[$], log_mwr[$], log_rgw[$];
  int log_rrd[$], log_br[$], log_err[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cls(input int op, input int fn);
    if (op == 0) return (fn == 8) ? C_JR : C_RT;
    if (op == 4 || op == 5) return C_BR;
    if (op == 40 || op == 41 || op == 43) return C_ST;
    if (op == 35) return C_LD;
    return C_IM;
  endfunction

  task automatic model_reset();
    m_s = 0; m_op = 0; m_fn = 0; m_cnt = 0; m_err = 0; m_to = 0; m_nmem = 0;
  endtask

  task automatic compare();
    int c;
    logic [10:0] e, a;
    c = cls(m_op, m_fn);
    e = {m_s == 0, (m_s == 0) && instr_valid,
         (m_s == 1 && m_op != 21) || (m_s == 3 && c == C_ST),
         m_s == 4, m_s == 4 && c == C_RT, m_s == 2 && c == C_BR,
         m_s == 3 && c == C_LD, m_s == 3 && c == C_ST,
         m_s == 5, m_s == 5, m_err};
    a = {instr_ready, ir_load, rg_read, rg_write, rg_dst, branch,
         m_read, m_write, pc_write, instr_done, mem_err};
    chk("outputs", int'(a), int'(e));
    chk("state", int'(state), m_s);
    chk("mrd_mwr_excl", int'(m_read & m_write), 0);
    log_st.push_back(int'(state));   log_done.push_back(int'(instr_done));
    log_mrd.push_back(int'(m_read)); log_mwr.push_back(int'(m_write));
    log_rgw.push_back(int'(rg_write)); log_rrd.push_back(int'(rg_read));
    log_br.push_back(int'(branch));  log_err.push_back(int'(mem_err));
  endtask

  // Advance the model over one rising edge using the inputs just sampled.
  task automatic model_step();
    int c, lat;
    cyc++;
    c = cls(m_op, m_fn);
    case (m_s)
      0: if (instr_valid) begin
           m_op = int'(opcode); m_fn = int'(funct);
           acc = cyc; m_nmem = 0; m_to = 0; m_s = 1;
         end
      1: m_s = 2;
      2: begin
           m_cnt = 0;
           if (c == C_BR || c == C_JR) m_s = 5;
           else if (c == C_LD || c == C_ST) m_s = 3;
           else m_s = 4;
         end
      3: begin
           m_nmem++;
           if (mem_ack) m_s = (c == C_LD) ? 4 : 5;
`ifdef CU_MEM_TIMEOUT_EN
           else begin
             m_cnt++;
             if (m_cnt == TMO) begin m_err = 1; m_to = 1; m_s = 5; end
           end
`endif
         end
      4: m_s = 5;
      default: begin
           case (c)
             C_BR, C_JR: lat = 3;
             C_ST:       lat = 3 + m_nmem;
             C_LD:       lat = m_to ? 3 + m_nmem : 4 + m_nmem;
             default:    lat = 4;
           endcase
           chk("latency", cyc - acc, lat);
           m_s = 0;
         end
    endcase
  endtask

  task automatic cycle(input bit v, input int op, input int fn, input bit ack);
    @(negedge clk);
    instr_valid = v; opcode = 6'(op); funct = 6'(fn); mem_ack = ack;
    #1 compare();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, ack);
  endtask

  // Asserts reset away from any edge and checks outputs before the next edge.
  task automatic do_reset();
    instr_valid = 0; mem_ack = 0;
    #3 rst_n = 0;
    model_reset();
    #1 compare();
    chk("reset_ready", int'(instr_ready), 1);
    chk("reset_state", int'(state), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic clear_logs();
    log_st.delete(); log_done.delete(); log_mrd.delete(); log_mwr.delete();
    log_rgw.delete(); log_rrd.delete(); log_br.delete(); log_err.delete();
  endtask

  function automatic int count(input int q[$]);
    int n = 0;
    foreach (q[i]) n += q[i];
    return n;
  endfunction

  initial begin
    int exp_rt[6]  = '{0, 1, 2, 4, 5, 0};
    int exp_jr[5]  = '{0, 1, 2, 5, 0};
    int exp_ld[10] = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 0};
    int exp_st[5]  = '{0, 1, 2, 3, 5};
    int r;
    cyc = 0; acc = 0;
    model_reset();
    #2 do_reset();

    // RTYPE add
    clear_logs();
    cycle(1, 0, 6'b100000, 0); idle(5, 0);
    for (int i = 0; i < 6; i++) chk("rt_seq", log_st[i], exp_rt[i]);
    chk("rt_read_decode", log_rrd[1], 1);
    chk("rt_write_wb", log_rgw[3], 1);
    chk("rt_done_idx", log_done[4], 1);
    chk("rt_done_cnt", count(log_done), 1);

    // JR
    clear_logs();
    cycle(1, 0, 6'b001000, 0); idle(4, 0);
    for (int i = 0; i < 5; i++) chk("jr_seq", log_st[i], exp_jr[i]);
    chk("jr_no_write", count(log_rgw), 0);

    // LOAD, ack low 3 MEM cycles then high
    clear_logs();
    cycle(1, 35, 0, 0); idle(5, 0); cycle(0, 0, 0, 1); idle(3, 0);
    for (int i = 0; i < 10; i++) chk("ld_seq", log_st[i], exp_ld[i]);
    chk("ld_mread_cnt", count(log_mrd), 4);
    chk("ld_done_idx", log_done[8], 1);
    chk("ld_wb_write", log_rgw[7], 1);

    // STORE with immediate ack
    clear_logs();
    cycle(1, 43, 0, 1); idle(4, 1);
    for (int i = 0; i < 5; i++) chk("st_seq", log_st[i], exp_st[i]);
    chk("st_mwrite_cnt", count(log_mwr), 1);
    chk("st_no_write", count(log_rgw), 0);
    chk("st_read_mem", log_rrd[3], 1);

    // Branch with valid held through DONE: accepted only in the next IDLE
    clear_logs();
    for (int i = 0; i < 6; i++) cycle(1, 4, 0, 0);
    idle(3, 0);
    chk("br_done_not_accepted", log_st[4], 0);
    chk("br_accept_after_done", log_st[5], 1);
    chk("br_exec_only", log_br[2], 1);
    chk("br_cnt", count(log_br), 2);

    // NOREAD opcode
    clear_logs();
    cycle(1, 21, 0, 0); idle(5, 0);
    chk("noread_decode", log_rrd[1], 0);

    // Reset while a LOAD waits in MEM
    cycle(1, 35, 0, 0); idle(4, 0);
    chk("pre_reset_mem", int'(state), 3);
    do_reset();
    chk("reset_mread_drop", int'(m_read), 0);
    clear_logs();
    cycle(1, 0, 6'b100000, 0); idle(5, 0);
    chk("post_reset_accept", log_st[1], 1);

`ifdef CU_MEM_TIMEOUT_EN
    clear_logs();
    cycle(1, 35, 0, 0); idle(9, 0);
    chk("tmo_err", log_err[7], 1);
    chk("tmo_done", log_st[7], 5);
    chk("tmo_no_write", count(log_rgw), 0);
    cycle(1, 0, 6'b100000, 0); idle(5, 0);
    chk("tmo_sticky", int'(mem_err), 1);
    do_reset();
    chk("tmo_cleared", int'(mem_err), 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      cycle($urandom_range(0, 1) == 1,
            (r == 0) ? 0 : (r == 1) ? 4 : (r == 2) ? 5 : (r == 3) ? 35 :
            (r == 4) ? 43 : (r == 5) ? 40 : (r == 6) ? 41 : (r == 7) ? 21 :
            $urandom_range(0, 63),
            ($urandom_range(0, 3) == 0) ? 8 : $urandom_range(0, 63),
            $urandom_range(0, 9) < 3);
      if (i == 1500) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequenced successor to the single-cycle combinational decoder.
- Accepts one instruction (OPCODE/FUNCT) per handshake, latches it, and steps it through DECODE/EXEC/MEM/WB/DONE states.
- Drives per-state register-file, memory, branch and PC controls, and waits on a memory acknowledge.
- Sits between the instruction fetch stage and the datapath of the multi-cycle core.

Parameters:
- OPCODE_W, 6, opcode field width
- FUNCT_W, 6, funct field width
- TMO_W, 8, width of memory-wait counter
- TMO_CYCLES, 200, memory-wait limit in cycles (used only with the optional feature)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- INSTR_VALID  in  1  instruction present on OPCODE/FUNCT
- OPCODE  in  OPCODE_W  instruction opcode
- FUNCT  in  FUNCT_W  R-type function field
- MEM_ACK  in  1  data memory completes the current access
- INSTR_READY  out  1  unit is in IDLE and will accept
- IR_LOAD  out  1  instruction accepted this cycle
- RG_READ  out  1  register file read enable
- RG_WRITE  out  1  register file write enable
- RG_DST  out  1  1 = rd destination, 0 = rt destination
- BRANCH  out  1  branch compare/update enable
- M_READ  out  1  data memory read request
- M_WRITE  out  1  data memory write request
- PC_WRITE  out  1  PC update strobe
- INSTR_DONE  out  1  one-cycle retire pulse
- STATE  out  3  current state encoding
- MEM_ERR  out  1  sticky memory timeout flag

Behaviour:
- Reset (RST_N low, at any time including mid-instruction):
  - State goes to IDLE immediately.
  - Latched IR_OP/IR_FN clear to 0; counter and MEM_ERR clear.
  - Every output is 0 except INSTR_READY=1 and STATE=0.
- State encodings: IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4, DONE=5. Codes 6 and 7 return to IDLE on the next edge.
- Output decode:
  - Outputs are Moore-style: decoded only from the state register and the latched IR_OP/IR_FN.
  - OPCODE/FUNCT are ignored outside IDLE.
- Instruction classes, decoded from the latched opcode:
  - RTYPE: op=0.
  - JR: op=0 and fn=6'b001000.
  - BR: op=4 or op=5.
  - STORE: op=40, 41 or 43.
  - LOAD: op=35.
  - NOREAD: op=21.
  - IMM: any other op.
- IDLE:
  - INSTR_READY=1.
  - On INSTR_VALID: IR_LOAD=1 (combinational, same cycle), latch OPCODE/FUNCT, go to DECODE.
- DECODE: RG_READ=1 unless NOREAD. Next state EXEC.
- EXEC:
  - BR: BRANCH=1, go to DONE.
  - LOAD or STORE: go to MEM.
  - JR: go to DONE.
  - RTYPE or IMM: go to WB.
- MEM:
  - LOAD: M_READ=1. STORE: M_WRITE=1 and RG_READ=1.
  - The request is held until MEM_ACK is sampled high.
  - On MEM_ACK: LOAD goes to WB; STORE goes to DONE.
  - If MEM_ACK is high on the first MEM cycle, MEM lasts exactly one cycle.
- WB:
  - RG_WRITE=1.
  - RG_DST=1 for RTYPE, 0 for IMM and LOAD.
  - Next state DONE.
- DONE:
  - PC_WRITE=1 and INSTR_DONE=1 for exactly one cycle.
  - Next state IDLE.
- Latency, counted in edges from the acceptance edge to the edge that ends DONE:
  - RTYPE/IMM: 4 cycles.
  - BR and JR: 3 cycles.
  - STORE: 3+N cycles, where N = number of MEM cycles (≥1).
  - LOAD: 4+N cycles.
- Back-to-back: INSTR_VALID held during DONE is not accepted. It is accepted in the following IDLE cycle.
- Mutual exclusion: M_READ and M_WRITE are never high together. RG_WRITE is never high outside WB.

Optional Feature:
- Macro: CU_MEM_TIMEOUT_EN.
- When defined:
  - A TMO_W-bit counter clears on MEM entry and increments on each MEM cycle without MEM_ACK.
  - When it reaches TMO_CYCLES: set MEM_ERR (sticky until reset), drop the memory request, and go to DONE.
  - On a timeout the LOAD skips WB, so RG_WRITE never asserts.
  - MEM_ACK on the same cycle as the limit wins: normal completion, no error.
- When undefined:
  - MEM waits indefinitely.
  - MEM_ERR is tied to 0 and the counter is absent.

Test Plan:
- Reset then OPCODE=0, FUNCT=6'b100000, valid 1 cycle:
  - STATE sequence 0,1,2,4,5,0.
  - RG_READ in DECODE; RG_WRITE=1 and RG_DST=1 in WB.
  - INSTR_DONE 4 cycles after acceptance.
- OPCODE=0, FUNCT=6'b001000 (JR):
  - STATE sequence 0,1,2,5,0.
  - RG_WRITE never asserts.
- OPCODE=35, MEM_ACK low 3 cycles then high:
  - M_READ high for exactly 4 cycles.
  - Then WB with RG_WRITE=1, RG_DST=0.
  - INSTR_DONE at cycle 8.
- OPCODE=43 with MEM_ACK high immediately:
  - M_WRITE and RG_READ for 1 cycle, no WB.
  - OPCODE=4 issued next: BRANCH=1 only in EXEC.
  - OPCODE=21: RG_READ stays 0 in DECODE.
- Mid-MEM (LOAD waiting): pull RST_N low asynchronously:
  - All outputs drop without waiting for a clock edge; INSTR_READY=1, STATE=0.
  - A new valid is accepted after release.
- With CU_MEM_TIMEOUT_EN and TMO_CYCLES=4, LOAD with MEM_ACK never high:
  - MEM_ERR rises, goes to DONE, no RG_WRITE.
  - MEM_ERR stays high over the next instruction until reset.
